shiftdes: RTL

Serial-to-parallel deserializer: the receive end of the `shiftreg` serial link. It samples a serial bit stream MSB first and frames it into WIDTH-bit words using a start marker. Completed words are presented on a valid/ready output register. It sits at the far end of the one-wire data path and feeds parallel consumers such as FIFOs or register files.

---
 rtl/shiftdes_if.sv | 29 ++
 rtl/shiftdes.sv | 118 +++++++++++
 2 files changed

// File: rtl/shiftdes_if.sv
// shiftdes_if: bundles the serial receive stream and the parallel read port
// of the shiftdes deserializer.
//   i_data, i_valid, i_start : serial bit stream (sender -> deserializer)
//   o_rd_data, o_rd_valid    : completed word register (deserializer -> consumer)
//   i_rd_ready               : consumer accepts the word
//   o_overrun, o_frame_err   : status flags
// Modports: slave = deserializer side, master = sender/consumer side.
interface shiftdes_if #(
  parameter int WIDTH = 8
);
  logic             i_data;
  logic             i_valid;
  logic             i_start;
  logic [WIDTH-1:0] o_rd_data;
  logic             o_rd_valid;
  logic             i_rd_ready;
  logic             o_overrun;
  logic             o_frame_err;

  modport slave (
    input  i_data, i_valid, i_start, i_rd_ready,
    output o_rd_data, o_rd_valid, o_overrun, o_frame_err
  );

  modport master (
    output i_data, i_valid, i_start, i_rd_ready,
    input  o_rd_data, o_rd_valid, o_overrun, o_frame_err
  );
endinterface

// File: rtl/shiftdes.sv
// shiftdes: serial-to-parallel deserializer. Samples an MSB-first bit stream,
// frames WIDTH-bit words on a start marker and presents completed words in a
// valid/ready output register.
// Ports:
//   clk   : rising-edge clock
//   i_rst : synchronous active-high reset
//   bus   : shiftdes_if.slave (serial input, read port, status flags)
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a bit flagged with i_start; other bits ignored
// RECV  | collecting bits of a word; cnt = bits already shifted in
module shiftdes #(
  parameter int WIDTH = 8
) (
  input  logic      clk,
  input  logic      i_rst,
  shiftdes_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             overrun_q, overrun_d;
  logic             frame_err_q, frame_err_d;

  logic [WIDTH-1:0] shifted;
  logic             complete;

  // Truncating cast drops the bit that falls off the top of the register.
  assign shifted = WIDTH'({sr_q, bus.i_data});

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    frame_err_d = 1'b0;
    complete    = 1'b0;

    if (bus.i_valid) begin
      unique case (state_q)
        IDLE: begin
          if (bus.i_start) begin
            sr_d    = shifted;
            cnt_d   = CW'(1);
            state_d = RECV;
          end
        end
        RECV: begin
          sr_d = shifted;
          if (bus.i_start) begin
            // Resync wins even over the would-be last bit.
            cnt_d       = CW'(1);
            frame_err_d = 1'b1;
          end else if (cnt_q == CW'(WIDTH - 1)) begin
            cnt_d    = '0;
            complete = 1'b1;
            state_d  = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    overrun_d  = overrun_q;

    if (complete) begin
      // A word being drained this cycle frees the register for the new one.
      if (!rd_valid_q || bus.i_rd_ready) begin
        rd_data_d  = shifted;
        rd_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rd_valid_q && bus.i_rd_ready) begin
      rd_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      cnt_q       <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.o_rd_data   = rd_data_q;
  assign bus.o_rd_valid  = rd_valid_q;
  assign bus.o_overrun   = overrun_q;
  assign bus.o_frame_err = frame_err_q;
endmodule
